// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a terminal flag at one; times the drain window and memory latency.
module mem_lat_counter #(
  parameter int             W         = 2,
  parameter logic [W-1:0]   RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between fetch and data requesters.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               LAT_W      = $clog2(MEM_LAT + 1);
  localparam int               SW         = $clog2(STARVE_LIM + 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIM);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_cancel;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;

  logic w_if_ok;
  logic w_gnt_dm;
  logic w_gnt_if;
  logic w_lat_dec;
  logic w_lat_last;
  logic w_busy_end;
  logic w_if_cancel;

  assign w_if_ok     = if_req & ~if_flush;
  assign w_lat_dec   = (r_state == ST_DRAIN) | ((r_state == ST_BUSY) & ~r_mem_en);
  assign w_busy_end  = (r_state == ST_BUSY) & ~r_mem_en & w_lat_last;
  assign w_if_cancel = (r_owner == OWN_IF) & (r_cancel | if_flush);

  // Data side wins unless fetch has lost too many times in a row; then fetch is forced through.
  always_comb begin
    w_gnt_dm = 1'b0;
    w_gnt_if = 1'b0;
    if (r_state == ST_IDLE) begin
      if (dm_req && (r_starve_cnt < STARVE_MAX)) begin
        w_gnt_dm = 1'b1;
      end else if (w_if_ok) begin
        w_gnt_if = 1'b1;
      end else if (dm_req) begin
        w_gnt_dm = 1'b1;
      end
    end
  end

  mem_lat_counter #(
    .W         (LAT_W),
    .RESET_VAL (LAT_INIT)
  ) u_lat (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gnt_dm | w_gnt_if),
    .i_load_val (LAT_INIT),
    .i_dec      (w_lat_dec),
    .o_last     (w_lat_last)
  );

  // Count consecutive fetch losses; any fetch win or an absent fetch request resets the streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_gnt_if) begin
      r_starve_cnt <= '0;
    end else if (w_gnt_dm && !if_flush && (r_starve_cnt < STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Access sequencer: drain after reset, issue one access, wait out the latency, report completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DRAIN;
      r_owner     <= OWN_IF;
      r_cancel    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      case (r_state)
        ST_DRAIN: begin
          if (w_lat_last) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_gnt_dm) begin
            r_owner     <= OWN_DM;
            r_cancel    <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_state     <= ST_BUSY;
          end else if (w_gnt_if) begin
            r_owner     <= OWN_IF;
            r_cancel    <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if ((r_owner == OWN_IF) && if_flush) begin
            r_cancel <= 1'b1;
          end
          if (w_busy_end) begin
            if (r_owner == OWN_IF) begin
              if (w_if_cancel) begin
                r_cancel <= 1'b0;
                r_state  <= ST_IDLE;
              end else begin
                r_if_rdata <= mem_rdata;
                r_if_done  <= 1'b1;
                r_state    <= ST_RESP;
              end
            end else begin
              if (!r_mem_we) begin
                r_dm_rdata <= mem_rdata;
              end
              r_dm_done <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_DRAIN;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_done   = r_if_done & ~if_flush;
  assign dm_done   = r_dm_done;
  assign stall_if  = if_req & ~if_done & ~if_flush;
  assign stall_mem = dm_req & ~dm_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with MEM_LAT=2, STARVE_LIM=4.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_LIM (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory image seen by reads that were never overwritten.
  function automatic logic [31:0] initWord(input logic [7:0] idx);
    case (idx)
      8'd16:   return 32'h8C010004;
      8'd17:   return 32'h00851020;
      8'd18:   return 32'h8FA20010;
      8'd19:   return 32'h11111111;
      8'd64:   return 32'h12345678;
      8'd65:   return 32'h55AA55AA;
      default: return {24'hC0FFEE, idx};
    endcase
  endfunction

  logic [31:0] wrArr [0:255];
  logic [255:0] wrValid;
  logic [1:0]  pipeV;
  logic [31:0] pipeD [0:1];
  logic [7:0]  memIdx;

  assign memIdx    = mem_addr[9:2];
  assign mem_rdata = pipeV[1] ? pipeD[1] : 32'hBAD0BAD0;

  // Fixed two-cycle-latency memory: read data appears two cycles after the strobe cycle.
  always @(posedge clk) begin
    if (rst) begin
      wrValid <= '0;
    end else if (mem_en && mem_we) begin
      wrArr[memIdx]   <= mem_wdata;
      wrValid[memIdx] <= 1'b1;
    end
    pipeV    <= {pipeV[0], mem_en && !mem_we};
    pipeD[0] <= wrValid[memIdx] ? wrArr[memIdx] : initWord(memIdx);
    pipeD[1] <= pipeD[0];
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic test_reset;
    logic expEn;
    logic expDone;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h44; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, if_done, dm_done} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {mem_en, mem_we, if_done, dm_done}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata}); end
    checks++; if ({stall_if, stall_mem} !== 2'b10) begin errors++; $display("[TB] FAIL reset_stalls got=%b exp=10", {stall_if, stall_mem}); end
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      expEn = (c == 3);
      expDone = (c == 6);
      checks++; if (mem_en !== expEn) begin errors++; $display("[TB] FAIL drain_mem_en c=%0d got=%b exp=%b", c, mem_en, expEn); end
      checks++; if (if_done !== expDone) begin errors++; $display("[TB] FAIL drain_if_done c=%0d got=%b exp=%b", c, if_done, expDone); end
      if (c == 6) begin
        checks++; if (if_rdata !== 32'h00851020) begin errors++; $display("[TB] FAIL drain_if_rdata got=%h exp=00851020", if_rdata); end
      end
      nextCycle();
    end
    if_req = 1'b0;
    idleGap(4);
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (mem_en !== (c == 1)) begin errors++; $display("[TB] FAIL fetch_mem_en c=%0d got=%b exp=%b", c, mem_en, (c == 1)); end
      checks++; if (if_done !== (c == 4)) begin errors++; $display("[TB] FAIL fetch_if_done c=%0d got=%b exp=%b", c, if_done, (c == 4)); end
      checks++; if (stall_if !== (c <= 3)) begin errors++; $display("[TB] FAIL fetch_stall_if c=%0d got=%b exp=%b", c, stall_if, (c <= 3)); end
      if (c == 1) begin
        checks++; if ({mem_addr, mem_we} !== {32'h40, 1'b0}) begin errors++; $display("[TB] FAIL fetch_issue got=%h/%b exp=00000040/0", mem_addr, mem_we); end
      end
      if (c == 3) begin
        checks++; if (if_rdata !== 32'h00851020) begin errors++; $display("[TB] FAIL fetch_rdata_early got=%h exp=00851020", if_rdata); end
      end
      if (c == 4) begin
        checks++; if (if_rdata !== 32'h8C010004) begin errors++; $display("[TB] FAIL fetch_rdata got=%h exp=8c010004", if_rdata); end
      end
      nextCycle();
    end
    if_req = 1'b0;
    idleGap(3);
  endtask

  task automatic test_dm_priority;
    logic expEn;
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int c = 0; c <= 9; c++) begin
      if (c == 5) dm_req = 1'b0;
      @(negedge clk);
      expEn = (c == 1) || (c == 6);
      checks++; if (mem_en !== expEn) begin errors++; $display("[TB] FAIL prio_mem_en c=%0d got=%b exp=%b", c, mem_en, expEn); end
      checks++; if (dm_done !== (c == 4)) begin errors++; $display("[TB] FAIL prio_dm_done c=%0d got=%b exp=%b", c, dm_done, (c == 4)); end
      checks++; if (if_done !== (c == 9)) begin errors++; $display("[TB] FAIL prio_if_done c=%0d got=%b exp=%b", c, if_done, (c == 9)); end
      if (c <= 4) begin
        checks++; if (stall_mem !== (c <= 3)) begin errors++; $display("[TB] FAIL prio_stall_mem c=%0d got=%b exp=%b", c, stall_mem, (c <= 3)); end
      end
      if (c == 1) begin
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL prio_dm_addr got=%h exp=00000100", mem_addr); end
      end
      if (c == 6) begin
        checks++; if (mem_addr !== 32'h44) begin errors++; $display("[TB] FAIL prio_if_addr got=%h exp=00000044", mem_addr); end
      end
      if (c == 4) begin
        checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL prio_dm_rdata got=%h exp=12345678", dm_rdata); end
      end
      if (c == 9) begin
        checks++; if (if_rdata !== 32'h00851020) begin errors++; $display("[TB] FAIL prio_if_rdata got=%h exp=00851020", if_rdata); end
      end
      nextCycle();
    end
    if_req = 1'b0;
    idleGap(3);
  endtask

  task automatic test_write;
    logic expEn;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 10; c++) begin
      if (c == 5) dm_req = 1'b0;
      if (c == 6) begin dm_req = 1'b1; dm_we = 1'b0; dm_wdata = 32'h0; end
      @(negedge clk);
      expEn = (c == 1) || (c == 7);
      checks++; if (mem_en !== expEn) begin errors++; $display("[TB] FAIL write_mem_en c=%0d got=%b exp=%b", c, mem_en, expEn); end
      checks++; if (dm_done !== ((c == 4) || (c == 10))) begin errors++; $display("[TB] FAIL write_dm_done c=%0d got=%b", c, dm_done); end
      if (c == 1) begin
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL write_issue got=%b/%h/%h exp=1/00000200/deadbeef", mem_we, mem_addr, mem_wdata); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL write_dm_rdata_hold c=%0d got=%h exp=12345678", c, dm_rdata); end
      end
      if (c == 7) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL readback_we got=%b exp=0", mem_we); end
      end
      if (c == 10) begin
        checks++; if (dm_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL readback_rdata got=%h exp=deadbeef", dm_rdata); end
      end
      nextCycle();
    end
    dm_req = 1'b0;
    idleGap(3);
  endtask

  task automatic test_starvation;
    logic [9:0] seenIf;
    int nGrants;
    seenIf = '0;
    nGrants = 0;
    if_req = 1'b1; if_addr = 32'h48;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    for (int c = 0; c <= 49; c++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && nGrants < 10) begin
        seenIf[nGrants] = (mem_addr === 32'h48);
        nGrants++;
      end
      nextCycle();
    end
    if_req = 1'b0; dm_req = 1'b0;
    checks++; if (nGrants != 10) begin errors++; $display("[TB] FAIL starve_grant_count got=%0d exp=10", nGrants); end
    checks++; if (seenIf[4:0] !== 5'b10000) begin errors++; $display("[TB] FAIL starve_first_round got=%b exp=10000", seenIf[4:0]); end
    checks++; if (seenIf[9:5] !== 5'b10000) begin errors++; $display("[TB] FAIL starve_second_round got=%b exp=10000", seenIf[9:5]); end
    checks++; if (if_rdata !== 32'h8FA20010) begin errors++; $display("[TB] FAIL starve_if_rdata got=%h exp=8fa20010", if_rdata); end
    idleGap(6);
  endtask

  task automatic test_flush_cancel;
    logic [31:0] expRd;
    if_req = 1'b1; if_addr = 32'h4C;
    for (int c = 0; c <= 8; c++) begin
      if (c == 1) if_flush = 1'b1;
      if (c == 2) begin if_flush = 1'b0; if_req = 1'b0; end
      if (c == 4) begin if_req = 1'b1; if_addr = 32'h40; end
      @(negedge clk);
      expRd = (c < 8) ? 32'h8FA20010 : 32'h8C010004;
      checks++; if (mem_en !== ((c == 1) || (c == 5))) begin errors++; $display("[TB] FAIL flush_mem_en c=%0d got=%b", c, mem_en); end
      checks++; if (if_done !== (c == 8)) begin errors++; $display("[TB] FAIL flush_if_done c=%0d got=%b exp=%b", c, if_done, (c == 8)); end
      checks++; if (if_rdata !== expRd) begin errors++; $display("[TB] FAIL flush_if_rdata c=%0d got=%h exp=%h", c, if_rdata, expRd); end
      if (c == 1) begin
        checks++; if (stall_if !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall_if got=%b exp=0", stall_if); end
      end
      nextCycle();
    end
    if_req = 1'b0;
    idleGap(3);
  endtask

  task automatic test_flush_idle;
    if_req = 1'b1; if_addr = 32'h48; if_flush = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) if_flush = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== (c == 2)) begin errors++; $display("[TB] FAIL flush_idle_mem_en c=%0d got=%b exp=%b", c, mem_en, (c == 2)); end
      checks++; if (if_done !== (c == 5)) begin errors++; $display("[TB] FAIL flush_idle_if_done c=%0d got=%b exp=%b", c, if_done, (c == 5)); end
      if (c <= 1) begin
        checks++; if (stall_if !== (c == 1)) begin errors++; $display("[TB] FAIL flush_idle_stall c=%0d got=%b exp=%b", c, stall_if, (c == 1)); end
      end
      if (c == 5) begin
        checks++; if (if_rdata !== 32'h8FA20010) begin errors++; $display("[TB] FAIL flush_idle_rdata got=%h exp=8fa20010", if_rdata); end
      end
      nextCycle();
    end
    if_req = 1'b0;
    idleGap(3);
  endtask

  task automatic test_reset_busy;
    logic [31:0] expDm;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    for (int c = 0; c <= 9; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) begin rst = 1'b0; dm_addr = 32'h100; end
      @(negedge clk);
      if (c >= 3) begin
        expDm = (c < 9) ? 32'h0 : 32'h12345678;
        checks++; if (mem_en !== (c == 6)) begin errors++; $display("[TB] FAIL rstbusy_mem_en c=%0d got=%b exp=%b", c, mem_en, (c == 6)); end
        checks++; if (dm_done !== (c == 9)) begin errors++; $display("[TB] FAIL rstbusy_dm_done c=%0d got=%b exp=%b", c, dm_done, (c == 9)); end
        checks++; if (dm_rdata !== expDm) begin errors++; $display("[TB] FAIL rstbusy_dm_rdata c=%0d got=%h exp=%h", c, dm_rdata, expDm); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstbusy_if_rdata c=%0d got=%h exp=0", c, if_rdata); end
      end
      if (c == 3) begin
        checks++; if ({mem_we, mem_addr, mem_wdata, if_done} !== 66'h0) begin errors++; $display("[TB] FAIL rstbusy_outputs got=%b/%h/%h/%b exp=0", mem_we, mem_addr, mem_wdata, if_done); end
      end
      nextCycle();
    end
    dm_req = 1'b0;
    idleGap(3);
  endtask

  // Bound the whole run so a stuck design still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_dm_priority();
    test_write();
    test_starvation();
    test_flush_cancel();
    test_flush_idle();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates one shared single-port, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. It sequences each access, returns read data, and produces the stall signals that the pipeline uses to freeze the PC and the pipeline registers. Data accesses have priority. A starvation limiter guarantees forward progress for fetch. It also supports fetch cancellation on branch redirect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (>=1)
STARVE_LIM, 4, consecutive lost IF arbitrations before IF is forced to win (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, held until if_done or if_flush
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  cancel any pending/in-flight fetch (branch taken)
if_rdata  out  DATA_W  fetched instruction, valid with if_done
if_done  out  1  one-cycle completion pulse for a fetch
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid with dm_done
dm_done  out  1  one-cycle completion pulse for a data access
stall_if  out  1  if_req & ~if_done & ~if_flush (combinational)
stall_mem  out  1  dm_req & ~dm_done (combinational)
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address, held from issue to response
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On reset: state=DRAIN; all outputs 0 except the combinational stalls; starve_cnt=0; lat_cnt=MEM_LAT.
- States: DRAIN, IDLE, BUSY, RESP. Owner register: OWN_IF/OWN_DM.
- DRAIN: no issue; lat_cnt decrements each cycle; go to IDLE when lat_cnt reaches 1. This discards any response in flight at reset.
- IDLE arbitration:
  - If dm_req and starve_cnt<STARVE_LIM, grant DM.
  - Else if if_req & ~if_flush, grant IF.
  - Else if dm_req, grant DM.
  - On grant: register mem_addr/mem_we/mem_wdata, mem_en=1 in the next cycle only, load lat_cnt=MEM_LAT, go to BUSY.
  - mem_we=0 for IF grants.
- starve_cnt: +1 (saturating at STARVE_LIM) when DM wins while if_req & ~if_flush; cleared on an IF grant or when if_req=0.
- BUSY: lat_cnt decrements each cycle after the mem_en cycle. In the cycle mem_rdata is valid (mem_en cycle + MEM_LAT), capture it into the owner's rdata register (reads only) and go to RESP.
- RESP (one cycle): the owner's done=1; return to IDLE. No arbitration in RESP; the served requester's req is ignored during RESP.
- Latency: req in cycle T (IDLE) -> mem_en T+1 -> done T+1+MEM_LAT+1 = T+MEM_LAT+2.
- Writes: dm_done pulses with the same latency; dm_rdata is unchanged.
- if_flush:
  - In IDLE, the IF request is not granted that cycle.
  - While IF owns BUSY, set the cancel flag. The access completes on memory, if_done is suppressed and if_rdata is unchanged, and the FSM goes BUSY->IDLE directly, skipping RESP.
  - In RESP with owner IF, if_done is suppressed.
- if_rdata and dm_rdata hold their values between accesses.
- rst in any state restarts at DRAIN.

Decomposition:
- Shared package mips_mem_pkg holds: the state enum (DRAIN/IDLE/BUSY/RESP), the owner encoding, and default MEM_LAT/STARVE_LIM constants.
- One sub-module, mem_lat_counter: loadable down-counter with a terminal flag, used for both DRAIN and BUSY timing.
- Arbitration and the starve counter stay inline.

Test Plan:
- MEM_LAT=2: reset, then if_req with if_addr=0x40 in cycle 0. Expect mem_en in cycle 1 with mem_addr=0x40 and mem_we=0. Model returns 0x8C010004 in cycle 3. Expect if_done=1 and if_rdata=0x8C010004 in cycle 4, with stall_if=1 in cycles 0-3.
- if_req and dm_req (read 0x100) both asserted in cycle 0. Expect DM granted first, dm_done at cycle 4, IF mem_en at cycle 6, if_done at cycle 9.
- dm_req write 0x200/0xDEADBEEF: mem_we=1, mem_wdata=0xDEADBEEF with mem_en. dm_done after 4 cycles; dm_rdata unchanged.
- dm_req held continuously with back-to-back accesses and if_req high, STARVE_LIM=4. Expect exactly 4 DM grants, then an IF grant, and starve_cnt back to 0.
- if_flush pulsed one cycle after an IF grant. Expect no if_done, if_rdata unchanged, FSM back in IDLE at cycle MEM_LAT+2, and the next request accepted immediately.
- rst asserted while BUSY. Expect all outputs 0 and no mem_en for MEM_LAT cycles (DRAIN); a late mem_rdata never appears on if_rdata or dm_rdata.
